// File: rtl/run_check_seq_if.sv
// run_check_seq_if: start/ack handshake with the processor plus data-memory and golden-image read ports
// Ports (master = sequencer side):
//   DutStart  out  start request to the processor
//   DutAck    in   done flag from the processor
//   MemAddr   out  data-memory read address; MemData returns one cycle later
//   GoldAddr  out  golden-image address (mirrors MemAddr); GoldData/GoldValid return one cycle later
interface run_check_seq_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          DutStart;
    logic          DutAck;
    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemData;
    logic [AW-1:0] GoldAddr;
    logic [DW-1:0] GoldData;
    logic          GoldValid;
    modport master (output DutStart, MemAddr, GoldAddr, input DutAck, MemData, GoldData, GoldValid);
    modport slave  (input DutStart, MemAddr, GoldAddr, output DutAck, MemData, GoldData, GoldValid);
endinterface

// File: rtl/run_check_seq.sv
// run_check_seq: runs NUM_PROG processor programs back-to-back and checks a memory region after each
// Ports:
//   Clk, Reset                clock, asynchronous active-high reset
//   Go                        one-cycle request to start a sequence (honoured in IDLE/DONE only)
//   RegionLo/RegionHi         per-program inclusive check window, program p at [p*AW +: AW]
//   bus                       processor handshake and memory/golden read ports (run_check_seq_if.master)
//   Busy/Done/Pass/TimedOut   sequence status
//   ErrCount/FirstErrAddr     saturating mismatch count and address of the first mismatch
//   ProgIdx                   current program index (NUM_PROG once finished)
//   CycleCount                per-program ack latency; counter exists only with RUN_CHECK_CYCLE_COUNT_EN defined
module run_check_seq #(
    parameter int  NUM_PROG  = 3,
    parameter int  AW        = 8,
    parameter int  DW        = 8,
    parameter int  START_LEN = 2,
    parameter int  TIMEOUT   = 65535,
    localparam int PW        = $clog2(NUM_PROG) + 1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Go,
    input  logic [NUM_PROG*AW-1:0] RegionLo,
    input  logic [NUM_PROG*AW-1:0] RegionHi,
    run_check_seq_if.master        bus,
    output logic                   Busy,
    output logic                   Done,
    output logic                   Pass,
    output logic                   TimedOut,
    output logic [15:0]            ErrCount,
    output logic [AW-1:0]          FirstErrAddr,
    output logic [PW-1:0]          ProgIdx,
    output logic [31:0]            CycleCount
);
    localparam int SW = $clog2(START_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, START, WAIT_ACK, SCAN, NEXT, DONE} state_e;

    state_e        state_q;
    logic [SW-1:0] start_cnt_q;
    logic [TW-1:0] wait_cnt_q;
    logic          seen_low_q, dut_start_q, cmp_q, timed_out_q;
    logic [AW-1:0] addr_q, cmp_addr_q, first_q, lo, hi;
    logic [15:0]   err_q, err_d;
    logic [PW-1:0] prog_q;
    logic [DW-1:0] mem_w, gold_w;
    logic          mismatch, ack_ok;

    always_comb begin
        lo       = RegionLo[int'(prog_q)*AW +: AW];
        hi       = RegionHi[int'(prog_q)*AW +: AW];
        mem_w    = bus.MemData;
        gold_w   = bus.GoldData;
        mismatch = cmp_q && bus.GoldValid && (mem_w != gold_w);
        err_d    = (mismatch && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
        // an Ack only counts once a low Ack has been seen since START, so a stale high level is ignored
        ack_ok   = bus.DutAck && seen_low_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            start_cnt_q <= '0;
            wait_cnt_q  <= '0;
            seen_low_q  <= 1'b0;
            dut_start_q <= 1'b0;
            cmp_q       <= 1'b0;
            timed_out_q <= 1'b0;
            addr_q      <= '0;
            cmp_addr_q  <= '0;
            first_q     <= '0;
            err_q       <= '0;
            prog_q      <= '0;
        end else begin
            // read response for the address issued last cycle is compared this cycle
            cmp_q      <= (state_q == SCAN);
            cmp_addr_q <= addr_q;
            err_q      <= err_d;
            if (mismatch && err_q == '0)
                first_q <= cmp_addr_q;
            if (state_q == START || state_q == WAIT_ACK)
                seen_low_q <= seen_low_q | ~bus.DutAck;
            case (state_q)
                IDLE, DONE: if (Go) begin
                    err_q       <= '0;
                    timed_out_q <= 1'b0;
                    first_q     <= '0;
                    prog_q      <= '0;
                    dut_start_q <= 1'b1;
                    start_cnt_q <= '0;
                    seen_low_q  <= 1'b0;
                    state_q     <= START;
                end
                START: if (start_cnt_q == SW'(START_LEN - 1)) begin
                    dut_start_q <= 1'b0;
                    wait_cnt_q  <= '0;
                    state_q     <= WAIT_ACK;
                end else
                    start_cnt_q <= start_cnt_q + 1'b1;
                WAIT_ACK: if (ack_ok) begin
                    if (lo <= hi)
                        addr_q <= lo;
                    state_q <= (lo > hi) ? NEXT : SCAN;
                end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                    timed_out_q <= 1'b1;
                    state_q     <= DONE;
                end else
                    wait_cnt_q <= wait_cnt_q + 1'b1;
                // stop on equality before incrementing so a window ending at the top address never wraps
                SCAN: if (addr_q == hi)
                    state_q <= NEXT;
                else
                    addr_q <= addr_q + 1'b1;
                NEXT: begin
                    prog_q <= prog_q + 1'b1;
                    if (prog_q == PW'(NUM_PROG - 1))
                        state_q <= DONE;
                    else begin
                        dut_start_q <= 1'b1;
                        start_cnt_q <= '0;
                        seen_low_q  <= 1'b0;
                        state_q     <= START;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef RUN_CHECK_CYCLE_COUNT_EN
    logic [31:0] cyc_cnt_q, cyc_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cyc_cnt_q <= '0;
            cyc_q     <= '0;
        end else if (state_q == START)
            cyc_cnt_q <= '0;
        else if (state_q == WAIT_ACK) begin
            if (ack_ok)
                cyc_q <= cyc_cnt_q;
            else if (cyc_cnt_q != 32'hFFFF_FFFF)
                cyc_cnt_q <= cyc_cnt_q + 32'd1;
        end
    end

    assign CycleCount = cyc_q;
`else
    assign CycleCount = '0;
`endif

    assign bus.DutStart = dut_start_q;
    assign bus.MemAddr  = addr_q;
    assign bus.GoldAddr = addr_q;
    assign Busy         = (state_q != IDLE) && (state_q != DONE);
    assign Done         = (state_q == DONE);
    assign Pass         = Done && (err_q == '0) && !timed_out_q;
    assign TimedOut     = timed_out_q;
    assign ErrCount     = err_q;
    assign FirstErrAddr = first_q;
    assign ProgIdx      = prog_q;
endmodule
